// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects active-low push buttons,
// emitting a clean level plus one-cycle press, release and long-press pulses per channel.
module button_conditioner #(
    parameter int N_BTN        = 4,
    parameter int DEBOUNCE_CYC = 270_000,
    parameter int LONG_CYC     = 27_000_000,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_clean,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] long_held
);
    localparam logic [1:0] REL = 2'd0;
    localparam logic [1:0] PRS = 2'd1;
    localparam logic [1:0] LNG = 2'd2;
    localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYC - 1);

    logic [N_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_BTN-1:0] clean_q, clean_d;
    logic [N_BTN-1:0] press_q, press_d, rel_q, rel_d, long_q, long_d, held_q, held_d;
    logic [N_BTN-1:0] diff, acc;
    logic [1:0]       state_q [N_BTN];
    logic [1:0]       state_d [N_BTN];
    logic [CNT_W-1:0] db_cnt_q [N_BTN];
    logic [CNT_W-1:0] db_cnt_d [N_BTN];
    logic [CNT_W-1:0] hold_cnt_q [N_BTN];
    logic [CNT_W-1:0] hold_cnt_d [N_BTN];

    assign diff = sync2_q ^ clean_q;

    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        clean_d    = clean_q;
        press_d    = '0;
        rel_d      = '0;
        long_d     = '0;
        held_d     = held_q;
        acc        = '0;
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        for (int i = 0; i < N_BTN; i++) begin
            acc[i]      = diff[i] && (db_cnt_q[i] == DB_MAX);
            db_cnt_d[i] = (diff[i] && !acc[i]) ? db_cnt_q[i] + CNT_W'(1) : '0;
            clean_d[i]  = acc[i] ? sync2_q[i] : clean_q[i];
            press_d[i]  = acc[i] && !sync2_q[i];
            rel_d[i]    = acc[i] && sync2_q[i];
            // A release outranks reaching the long-press threshold on the same edge.
            if (press_d[i]) begin
                state_d[i]    = PRS;
                hold_cnt_d[i] = '0;
            end else if (rel_d[i]) begin
                state_d[i] = REL;
                held_d[i]  = 1'b0;
            end else if (state_q[i] == PRS) begin
                if (hold_cnt_q[i] == LONG_MAX) begin
                    state_d[i] = LNG;
                    long_d[i]  = 1'b1;
                    held_d[i]  = 1'b1;
                end else begin
                    hold_cnt_d[i] = hold_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            clean_q    <= '1;
            press_q    <= '0;
            rel_q      <= '0;
            long_q     <= '0;
            held_q     <= '0;
            state_q    <= '{default: REL};
            db_cnt_q   <= '{default: '0};
            hold_cnt_q <= '{default: '0};
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            clean_q    <= clean_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            long_q     <= long_d;
            held_q     <= held_d;
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign btn_clean     = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_pulse    = long_q;
    assign long_held     = held_q;
endmodule
